// File: rtl/cpp_internal_bool_period_to_double_if.sv
// cpp_internal_bool_period_to_double_if: bool/update-event input and double/update-toggle output bundle
interface cpp_internal_bool_period_to_double_if;
  logic        in;
  logic        update_in;
  logic [63:0] out;
  logic        update_out;
  logic        overrun;
  modport master (output in, update_in, input out, update_out, overrun);
  modport slave (input in, update_in, output out, update_out, overrun);
endinterface

// File: rtl/cpp_internal_bool_period_to_double.sv
// cpp_internal_bool_period_to_double: measures the cycle period between sampled rising edges and emits it as an IEEE-754 double
module cpp_internal_bool_period_to_double #(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  cpp_internal_bool_period_to_double_if.slave bus
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t state, state_d;
  logic update_in_q, in_q, armed;
  logic [CNT_W-1:0] counter, m;
  logic [10:0] e;
  logic [51:0] frac;
  logic evt, rise, start;
  assign evt = bus.update_in ^ update_in_q;
  assign rise = evt & bus.in & ~in_q;
  assign start = rise & armed & (state == IDLE);
  // drop the implicit leading one and left-align the rest into the 52-bit fraction
  assign frac = 52'(m[CNT_W-2:0]) << (53 - CNT_W);
  always_comb begin
    state_d = state == IDLE ? (start ? NORM : IDLE) :
              state == NORM ? (m[CNT_W-1] ? DONE : NORM) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      update_in_q    <= 1'b0;
      in_q           <= 1'b0;
      armed          <= 1'b0;
      counter        <= '0;
      m              <= '0;
      e              <= '0;
      bus.out        <= '0;
      bus.update_out <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      update_in_q <= bus.update_in;
      if (evt) in_q <= bus.in;
      counter <= rise ? CNT_W'(1) : (&counter ? counter : counter + CNT_W'(1));
      if (rise) armed <= 1'b1;
      if (rise && armed && state != IDLE) bus.overrun <= 1'b1;
      if (start) begin
        m <= counter;
        e <= 11'(CNT_W - 1);
      end else if (state == NORM && !m[CNT_W-1]) begin
        m <= m << 1;
        e <= e - 11'd1;
      end
      if (state == DONE) begin
        bus.out        <= {1'b0, 11'd1023 + e, frac};
        bus.update_out <= ~bus.update_out;
      end
      state <= state_d;
    end
  end
endmodule

// File: tb/tb_cpp_internal_bool_period_to_double.sv
// tb_cpp_internal_bool_period_to_double: directed checks of period measurement, latency, overrun, saturation and reset
module tb_cpp_internal_bool_period_to_double;
  logic clk = 1'b0;
  logic rst_n;
  logic in_v, upd_v;
  int compared = 0;
  int mismatched = 0;

  cpp_internal_bool_period_to_double_if b32 ();
  cpp_internal_bool_period_to_double_if b8 ();
  assign b32.in = in_v;
  assign b32.update_in = upd_v;
  assign b8.in = in_v;
  assign b8.update_in = upd_v;

  cpp_internal_bool_period_to_double #(.CNT_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  cpp_internal_bool_period_to_double #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  always #5 clk = ~clk;

  task automatic cycle(input logic i, input logic tog);
    in_v = i;
    if (tog) upd_v = ~upd_v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    in_v = 1'b0;
    upd_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b0);
  endtask

  // toggles update_in each cycle until b32 update_out changes; n > 199 means it never did
  task automatic wait_toggle(input logic alt, output int n);
    logic prev, v;
    prev = b32.update_out;
    v = 1'b1;
    n = 0;
    do begin
      if (alt) v = ~v;
      cycle(v, 1'b1);
      n++;
    end while (b32.update_out === prev && n < 200);
  endtask

  task automatic test_first_measurement;
    int n;
    do_reset;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b1);
    compared++;
    if (b32.update_out !== 1'b0 || b32.out !== 64'h0) begin
      mismatched++;
      $display("FAIL first_rise_silent: update_out=%b out=%h required 0/0", b32.update_out, b32.out);
    end
    cycle(1'b1, 1'b1);
    wait_toggle(1'b0, n);
    compared++;
    if (n !== 30) begin
      mismatched++;
      $display("FAIL first_latency: got %0d cycles required 30", n);
    end
    compared++;
    if (b32.out !== 64'h4024000000000000) begin
      mismatched++;
      $display("FAIL first_value: got %h required 4024000000000000", b32.out);
    end
    compared++;
    if (b32.update_out !== 1'b1 || b32.overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL first_flags: update_out=%b overrun=%b required 1/0", b32.update_out, b32.overrun);
    end
  endtask

  task automatic test_min_period;
    int n;
    do_reset;
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    wait_toggle(1'b1, n);
    compared++;
    if (n !== 32) begin
      mismatched++;
      $display("FAIL min_latency: got %0d cycles required 32", n);
    end
    compared++;
    if (b32.out !== 64'h4000000000000000) begin
      mismatched++;
      $display("FAIL min_value: got %h required 4000000000000000", b32.out);
    end
    compared++;
    if (b32.overrun !== 1'b1) begin
      mismatched++;
      $display("FAIL min_overrun: got %b required 1", b32.overrun);
    end
    for (int k = 0; k < 60; k++) cycle(1'(k % 2), 1'b1);
    compared++;
    if (b32.overrun !== 1'b1 || b32.out !== 64'h4000000000000000) begin
      mismatched++;
      $display("FAIL min_sticky: overrun=%b out=%h required 1/4000000000000000", b32.overrun, b32.out);
    end
  endtask

  task automatic test_reset;
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (b32.out !== 64'h0 || b32.update_out !== 1'b0 || b32.overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: out=%h update_out=%b overrun=%b required 0/0/0", b32.out, b32.update_out, b32.overrun);
    end
    in_v = 1'b0;
    upd_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (b32.out !== 64'h0 || b32.update_out !== 1'b0 || b32.overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_hold: out=%h update_out=%b overrun=%b required 0/0/0", b32.out, b32.update_out, b32.overrun);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_saturation;
    logic p8, p32;
    int n8, n32;
    do_reset;
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    repeat (299) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    p8 = b8.update_out;
    p32 = b32.update_out;
    n8 = 0;
    n32 = 0;
    for (int k = 1; k <= 100 && n32 == 0; k++) begin
      cycle(1'b1, 1'b1);
      if (n8 == 0 && b8.update_out !== p8) n8 = k;
      if (b32.update_out !== p32) n32 = k;
    end
    compared++;
    if (n8 !== 2 || b8.out !== 64'h406FE00000000000) begin
      mismatched++;
      $display("FAIL sat8: latency=%0d out=%h required 2/406fe00000000000", n8, b8.out);
    end
    compared++;
    if (n32 !== 25 || b32.out !== 64'h4072C00000000000) begin
      mismatched++;
      $display("FAIL wide300: latency=%0d out=%h required 25/4072c00000000000", n32, b32.out);
    end
  endtask

  task automatic test_no_event;
    int n, bad;
    do_reset;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'(k % 2), 1'b0);
      if (b32.update_out !== 1'b0) bad++;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL static_update: got %0d toggled cycles required 0", bad);
    end
    cycle(1'b1, 1'b1);
    repeat (40) cycle(1'b0, 1'b1);
    compared++;
    if (b32.update_out !== 1'b0) begin
      mismatched++;
      $display("FAIL gated_arm: update_out=%b required 0", b32.update_out);
    end
    cycle(1'b1, 1'b1);
    wait_toggle(1'b0, n);
    compared++;
    if (n !== 28 || b32.out !== 64'h4044800000000000) begin
      mismatched++;
      $display("FAIL gated_value: latency=%0d out=%h required 28/4044800000000000", n, b32.out);
    end
  endtask

  task automatic test_reset_mid_norm;
    int n;
    do_reset;
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    repeat (9) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    repeat (10) cycle(1'b1, 1'b1);
    rst_n = 1'b0;
    in_v = 1'b0;
    upd_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) cycle(1'b0, 1'b1);
    compared++;
    if (b32.update_out !== 1'b0 || b32.out !== 64'h0) begin
      mismatched++;
      $display("FAIL abort_silent: update_out=%b out=%h required 0/0", b32.update_out, b32.out);
    end
    cycle(1'b1, 1'b1);
    repeat (40) cycle(1'b0, 1'b1);
    compared++;
    if (b32.update_out !== 1'b0) begin
      mismatched++;
      $display("FAIL rearm_only: update_out=%b required 0", b32.update_out);
    end
    cycle(1'b1, 1'b1);
    wait_toggle(1'b0, n);
    compared++;
    if (n !== 28 || b32.out !== 64'h4044800000000000) begin
      mismatched++;
      $display("FAIL after_abort: latency=%0d out=%h required 28/4044800000000000", n, b32.out);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_v = 1'b0;
    upd_v = 1'b0;
    test_first_measurement;
    test_min_period;
    test_reset;
    test_saturation;
    test_no_event;
    test_reset_mid_norm;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
